// File: rtl/shiftreg_tdm_ctrl_pkg.sv
// Shared helpers for the TDM delay-line controller: index widths, RAM address
// packing and channel length clamping.
package shiftreg_tdm_ctrl_pkg;

  // Index width for n items, never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Packs {ch, ptr} into a flat RAM address; caller truncates to its width.
  function automatic logic [31:0] pack_addr(input int unsigned ch,
                                            input int unsigned ptr,
                                            input int unsigned ptr_w);
    return 32'((ch << ptr_w) | ptr);
  endfunction

  function automatic int unsigned clamp_len(input int unsigned len,
                                            input int unsigned size);
    if (len < 1) return 1;
    if (len > size) return size;
    return len;
  endfunction

endpackage

// File: rtl/shiftreg_tdm_ctrl_arb.sv
// Round-robin arbiter: first eligible requester at or after rr, modulo N.
module rr_arbiter
  import shiftreg_tdm_ctrl_pkg::*;
#(
  parameter int unsigned N = 4,
  localparam int unsigned IW = idx_width(N)
) (
  input  logic [N-1:0]  req,
  input  logic [N-1:0]  mask,
  input  logic [IW-1:0] rr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          valid
);

  logic [N-1:0]  elig;
  logic [IW-1:0] cand;

  assign elig = req & ~mask;

  always_comb begin
    idx   = '0;
    valid = 1'b0;
    cand  = '0;
    for (int unsigned i = 0; i < N; i++) begin
      cand = IW'((32'(rr) + i) % N);
      if (!valid && elig[cand]) begin
        valid = 1'b1;
        idx   = cand;
      end
    end
  end

  assign gnt = valid ? (N'(1) << idx) : '0;

endmodule

// File: rtl/shiftreg_tdm_ctrl.sv
// Time-division controller sharing one dual-port RAM between NCH circular
// delay lines; emits each channel's sample from len[c] pushes earlier.
module shiftreg_tdm_ctrl
  import shiftreg_tdm_ctrl_pkg::*;
#(
  parameter int unsigned NCH   = 4,
  parameter int unsigned SIZE  = 512,
  parameter int unsigned WIDTH = 16,
  localparam int unsigned ADDR = idx_width(SIZE),
  localparam int unsigned CHW  = idx_width(NCH)
) (
  input  logic                   CLK,
  input  logic                   reset_n,
  input  logic                   CLK_en,
  input  logic [NCH-1:0]         req,
  input  logic [NCH*WIDTH-1:0]   shiftin_bus,
  output logic [NCH-1:0]         gnt,
  input  logic                   cfg_we,
  input  logic [CHW-1:0]         cfg_ch,
  input  logic [ADDR:0]          cfg_len,
  output logic                   ram_we,
  output logic [CHW+ADDR-1:0]    ram_wr_addr,
  output logic [WIDTH-1:0]       ram_wdata,
  output logic                   ram_rd_en,
  output logic [CHW+ADDR-1:0]    ram_rd_addr,
  input  logic [WIDTH-1:0]       ram_rdata,
  output logic                   out_valid,
  output logic [CHW-1:0]         out_ch,
  output logic [WIDTH-1:0]       out_data
);

  localparam int unsigned LW = ADDR + 1;
  localparam int unsigned AW = CHW + ADDR;

  logic [LW-1:0]    len_q [NCH];
  logic [LW-1:0]    len_d [NCH];
  logic [ADDR-1:0]  ptr_q [NCH];
  logic [ADDR-1:0]  ptr_d [NCH];
  logic [LW-1:0]    cnt_q [NCH];
  logic [LW-1:0]    cnt_d [NCH];
  logic [CHW-1:0]   rr_q, rr_d;
  logic             s1_valid_q, s1_valid_d;
  logic [CHW-1:0]   s1_ch_q, s1_ch_d;
  logic             out_valid_q, out_valid_d;
  logic [CHW-1:0]   out_ch_q, out_ch_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;

  logic [NCH-1:0]   cfg_mask;
  logic [NCH-1:0]   arb_gnt;
  logic [CHW-1:0]   arb_idx;
  logic             arb_valid;
  logic             push;
  logic             full;

  // A channel being reconfigured cannot be granted in the same cycle.
  assign cfg_mask = cfg_we ? (NCH'(1) << cfg_ch) : '0;

  rr_arbiter #(.N(NCH)) u_arb (
    .req   (req),
    .mask  (cfg_mask),
    .rr    (rr_q),
    .gnt   (arb_gnt),
    .idx   (arb_idx),
    .valid (arb_valid)
  );

  assign push        = CLK_en & arb_valid;
  assign full        = (cnt_q[arb_idx] == len_q[arb_idx]);
  assign gnt         = CLK_en ? arb_gnt : '0;
  assign ram_we      = push;
  assign ram_rd_en   = push & full;
  assign ram_wr_addr = AW'(pack_addr(32'(arb_idx), 32'(ptr_q[arb_idx]), ADDR));
  assign ram_rd_addr = ram_wr_addr;
  assign ram_wdata   = shiftin_bus[32'(arb_idx)*WIDTH +: WIDTH];

  assign out_valid = out_valid_q;
  assign out_ch    = out_ch_q;
  assign out_data  = out_data_q;

  // Channel bookkeeping, round-robin pointer and 2-stage read pipeline.
  always_comb begin
    len_d       = len_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    rr_d        = rr_q;
    s1_valid_d  = s1_valid_q;
    s1_ch_d     = s1_ch_q;
    out_valid_d = out_valid_q;
    out_ch_d    = out_ch_q;
    out_data_d  = out_data_q;
    if (CLK_en) begin
      s1_valid_d  = ram_rd_en;
      s1_ch_d     = arb_idx;
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_ch_d   = s1_ch_q;
        out_data_d = ram_rdata;
      end
      if (push) begin
        ptr_d[arb_idx] = ({1'b0, ptr_q[arb_idx]} == len_q[arb_idx] - LW'(1))
                         ? '0 : ptr_q[arb_idx] + 1'b1;
        cnt_d[arb_idx] = full ? cnt_q[arb_idx] : cnt_q[arb_idx] + 1'b1;
        rr_d           = (arb_idx == CHW'(NCH - 1)) ? '0 : arb_idx + 1'b1;
      end
      if (cfg_we) begin
        len_d[cfg_ch] = LW'(clamp_len(32'(cfg_len), SIZE));
        ptr_d[cfg_ch] = '0;
        cnt_d[cfg_ch] = '0;
      end
    end
  end

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < NCH; i++) begin
        len_q[i] <= LW'(SIZE);
        ptr_q[i] <= '0;
        cnt_q[i] <= '0;
      end
      rr_q        <= '0;
      s1_valid_q  <= 1'b0;
      s1_ch_q     <= '0;
      out_valid_q <= 1'b0;
      out_ch_q    <= '0;
      out_data_q  <= '0;
    end else begin
      len_q       <= len_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      rr_q        <= rr_d;
      s1_valid_q  <= s1_valid_d;
      s1_ch_q     <= s1_ch_d;
      out_valid_q <= out_valid_d;
      out_ch_q    <= out_ch_d;
      out_data_q  <= out_data_d;
    end
  end

endmodule

// File: tb/tb_shiftreg_tdm_ctrl.sv
// Directed bench for shiftreg_tdm_ctrl with a read-first RAM model
// (NCH=4, SIZE=16, WIDTH=16).
module tb_shiftreg_tdm_ctrl;

  logic        CLK = 1'b0;
  logic        reset_n;
  logic        CLK_en;
  logic [3:0]  req;
  logic [63:0] shiftin_bus;
  logic [3:0]  gnt;
  logic        cfg_we;
  logic [1:0]  cfg_ch;
  logic [4:0]  cfg_len;
  logic        ram_we;
  logic [5:0]  ram_wr_addr;
  logic [15:0] ram_wdata;
  logic        ram_rd_en;
  logic [5:0]  ram_rd_addr;
  logic [15:0] ram_rdata;
  logic        out_valid;
  logic [1:0]  out_ch;
  logic [15:0] out_data;

  int n_cmp;
  int n_fail;

  shiftreg_tdm_ctrl #(.NCH(4), .SIZE(16), .WIDTH(16)) dut (
    .CLK(CLK), .reset_n(reset_n), .CLK_en(CLK_en), .req(req),
    .shiftin_bus(shiftin_bus), .gnt(gnt), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
    .cfg_len(cfg_len), .ram_we(ram_we), .ram_wr_addr(ram_wr_addr),
    .ram_wdata(ram_wdata), .ram_rd_en(ram_rd_en), .ram_rd_addr(ram_rd_addr),
    .ram_rdata(ram_rdata), .out_valid(out_valid), .out_ch(out_ch),
    .out_data(out_data)
  );

  always #5 CLK = ~CLK;

  // Read-first dual-port RAM, frozen while CLK_en is low.
  logic [15:0] mem [64];
  always @(posedge CLK) begin
    if (CLK_en) begin
      if (ram_rd_en) ram_rdata <= mem[ram_rd_addr];
      if (ram_we) mem[ram_wr_addr] <= ram_wdata;
    end
  end

  typedef struct {
    logic [3:0]  req;
    logic [15:0] d;
    logic        cw;
    logic [1:0]  cc;
    logic [4:0]  cl;
    logic [3:0]  e_gnt;
    logic        e_rd;
    logic [5:0]  e_wa;
    logic        e_ov;
    logic [15:0] e_od;
  } vec_t;

  vec_t tbl [14];

  function automatic vec_t mk(input logic [3:0] r, input logic [15:0] d,
                              input logic cw, input logic [1:0] cc,
                              input logic [4:0] cl, input logic [3:0] eg,
                              input logic erd, input logic [5:0] ewa,
                              input logic eov, input logic [15:0] eod);
    vec_t v;
    v.req = r; v.d = d; v.cw = cw; v.cc = cc; v.cl = cl;
    v.e_gnt = eg; v.e_rd = erd; v.e_wa = ewa; v.e_ov = eov; v.e_od = eod;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic en, input logic [3:0] r,
                       input logic [15:0] d, input logic cw,
                       input logic [1:0] cc, input logic [4:0] cl);
    CLK_en = en; req = r; shiftin_bus = {4{d}};
    cfg_we = cw; cfg_ch = cc; cfg_len = cl;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  int unsigned eptr_wrap [7] = '{0, 1, 2, 0, 1, 2, 0};
  int unsigned eptr_col  [6] = '{0, 1, 2, 3, 4, 0};
  logic        en_pat    [14] = '{1,1,1,1,0,0,0,1,1,1,1,1,1,1};
  logic [15:0] got [$];
  int          np;

  initial begin
    n_cmp = 0;
    n_fail = 0;
    reset_n = 1'b0;
    drive(1'b1, 4'h0, 16'h0, 1'b0, 2'd0, 5'd1);
    #3;
    chk("reset_out_valid", 32'(out_valid), 0);
    chk("reset_out_ch", 32'(out_ch), 0);
    chk("reset_out_data", 32'(out_data), 0);
    @(posedge CLK);
    #1;
    reset_n = 1'b1;

    // Single channel, len[0]=4, pushes 1..10.
    tbl[0]  = mk(4'h0,  0, 1, 0, 4, 4'h0, 0, 0, 0, 0);
    tbl[1]  = mk(4'h1,  1, 0, 0, 0, 4'h1, 0, 0, 0, 0);
    tbl[2]  = mk(4'h1,  2, 0, 0, 0, 4'h1, 0, 1, 0, 0);
    tbl[3]  = mk(4'h1,  3, 0, 0, 0, 4'h1, 0, 2, 0, 0);
    tbl[4]  = mk(4'h1,  4, 0, 0, 0, 4'h1, 0, 3, 0, 0);
    tbl[5]  = mk(4'h1,  5, 0, 0, 0, 4'h1, 1, 0, 0, 0);
    tbl[6]  = mk(4'h1,  6, 0, 0, 0, 4'h1, 1, 1, 0, 0);
    tbl[7]  = mk(4'h1,  7, 0, 0, 0, 4'h1, 1, 2, 1, 1);
    tbl[8]  = mk(4'h1,  8, 0, 0, 0, 4'h1, 1, 3, 1, 2);
    tbl[9]  = mk(4'h1,  9, 0, 0, 0, 4'h1, 1, 0, 1, 3);
    tbl[10] = mk(4'h1, 10, 0, 0, 0, 4'h1, 1, 1, 1, 4);
    tbl[11] = mk(4'h0,  0, 0, 0, 0, 4'h0, 0, 0, 1, 5);
    tbl[12] = mk(4'h0,  0, 0, 0, 0, 4'h0, 0, 0, 1, 6);
    tbl[13] = mk(4'h0,  0, 0, 0, 0, 4'h0, 0, 0, 0, 0);
    for (int i = 0; i < 14; i++) begin
      drive(1'b1, tbl[i].req, tbl[i].d, tbl[i].cw, tbl[i].cc, tbl[i].cl);
      #2;
      chk("tbl_gnt", 32'(gnt), 32'(tbl[i].e_gnt));
      chk("tbl_ram_we", 32'(ram_we), 32'(tbl[i].e_gnt != 4'h0));
      chk("tbl_ram_rd_en", 32'(ram_rd_en), 32'(tbl[i].e_rd));
      if (tbl[i].e_gnt != 4'h0) begin
        chk("tbl_wr_addr", 32'(ram_wr_addr), 32'(tbl[i].e_wa));
        chk("tbl_rd_addr", 32'(ram_rd_addr), 32'(tbl[i].e_wa));
        chk("tbl_wdata", 32'(ram_wdata), 32'(tbl[i].d));
      end
      chk("tbl_out_valid", 32'(out_valid), 32'(tbl[i].e_ov));
      if (tbl[i].e_ov) begin
        chk("tbl_out_ch", 32'(out_ch), 0);
        chk("tbl_out_data", 32'(out_data), 32'(tbl[i].e_od));
      end
      tick();
    end

    // Fairness from rr=0 after a mid-cycle reset.
    drive(1'b1, 4'h0, 16'h0, 1'b0, 2'd0, 5'd1);
    reset_n = 1'b0;
    #2;
    reset_n = 1'b1;
    tick();
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 4'hF, 16'(50 + i), 1'b0, 2'd0, 5'd1);
      #2;
      chk("fair_gnt", 32'(gnt), 32'(1) << (i % 4));
      chk("fair_wr_addr", 32'(ram_wr_addr), 32'((i % 4) * 16 + i / 4));
      tick();
    end

    // Wrap: len[2]=3, seven pushes.
    drive(1'b1, 4'h0, 16'h0, 1'b1, 2'd2, 5'd3);
    #2;
    chk("wrap_cfg_gnt", 32'(gnt), 0);
    tick();
    for (int m = 0; m < 10; m++) begin
      if (m < 7) drive(1'b1, 4'b0100, 16'(m + 1), 1'b0, 2'd0, 5'd1);
      else       drive(1'b1, 4'b0000, 16'h0, 1'b0, 2'd0, 5'd1);
      #2;
      if (m < 7) begin
        chk("wrap_gnt", 32'(gnt), 32'h4);
        chk("wrap_addr", 32'(ram_wr_addr), 32 + eptr_wrap[m]);
        chk("wrap_rd_en", 32'(ram_rd_en), 32'(m >= 3));
      end
      chk("wrap_out_valid", 32'(out_valid), 32'(m >= 5 && m <= 8));
      if (m >= 5 && m <= 8) begin
        chk("wrap_out_ch", 32'(out_ch), 2);
        chk("wrap_out_data", 32'(out_data), 32'(m - 4));
      end
      tick();
    end

    // Config collision on ch1: config wins, other channels still arbitrate.
    drive(1'b1, 4'b0010, 16'd99, 1'b1, 2'd1, 5'd5);
    #2;
    chk("col_gnt", 32'(gnt), 0);
    chk("col_ram_we", 32'(ram_we), 0);
    tick();
    drive(1'b1, 4'b0011, 16'd98, 1'b1, 2'd1, 5'd5);
    #2;
    chk("col_other_gnt", 32'(gnt), 32'h1);
    chk("col_other_addr", 32'(ram_wr_addr), 2);
    tick();
    for (int k = 0; k < 8; k++) begin
      if (k < 6) drive(1'b1, 4'b0010, 16'(101 + k), 1'b0, 2'd0, 5'd1);
      else       drive(1'b1, 4'b0000, 16'h0, 1'b0, 2'd0, 5'd1);
      #2;
      if (k < 6) begin
        chk("col_push_gnt", 32'(gnt), 32'h2);
        chk("col_push_addr", 32'(ram_wr_addr), 16 + eptr_col[k]);
        chk("col_push_rd_en", 32'(ram_rd_en), 32'(k == 5));
      end
      chk("col_out_valid", 32'(out_valid), 32'(k == 7));
      if (k == 7) begin
        chk("col_out_ch", 32'(out_ch), 1);
        chk("col_out_data", 32'(out_data), 101);
      end
      tick();
    end

    // len=0 clamps to 1 on ch3; stream with a 3-cycle CLK_en gap.
    drive(1'b1, 4'h0, 16'h0, 1'b1, 2'd3, 5'd0);
    tick();
    np = 0;
    for (int i = 0; i < 14; i++) begin
      drive(en_pat[i], (np < 8) ? 4'b1000 : 4'b0000, 16'(201 + np),
            1'b0, 2'd0, 5'd1);
      #2;
      if (!en_pat[i]) begin
        chk("hold_gnt", 32'(gnt), 0);
        chk("hold_ram_we", 32'(ram_we), 0);
        chk("hold_ram_rd_en", 32'(ram_rd_en), 0);
        chk("hold_out_valid", 32'(out_valid), 1);
        chk("hold_out_data", 32'(out_data), 202);
      end else if (out_valid) begin
        got.push_back(out_data);
        chk("hold_out_ch", 32'(out_ch), 3);
      end
      if (en_pat[i] && np < 8) np++;
      tick();
    end
    chk("hold_count", 32'(got.size()), 7);
    for (int i = 0; i < got.size() && i < 7; i++)
      chk("hold_seq", 32'(got[i]), 32'(201 + i));

    // Async reset while out_valid is high drops the pipeline; len returns to SIZE.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 4'b1000, 16'(401 + i), 1'b0, 2'd0, 5'd1);
      tick();
    end
    drive(1'b1, 4'b0000, 16'h0, 1'b0, 2'd0, 5'd1);
    #2;
    chk("pre_reset_valid", 32'(out_valid), 1);
    reset_n = 1'b0;
    #1;
    chk("async_out_valid", 32'(out_valid), 0);
    chk("async_out_ch", 32'(out_ch), 0);
    chk("async_out_data", 32'(out_data), 0);
    #1;
    reset_n = 1'b1;
    tick();
    for (int k = 0; k < 19; k++) begin
      if (k < 17) drive(1'b1, 4'b0001, 16'(301 + k), 1'b0, 2'd0, 5'd1);
      else        drive(1'b1, 4'b0000, 16'h0, 1'b0, 2'd0, 5'd1);
      #2;
      if (k < 17) chk("rst_len_rd_en", 32'(ram_rd_en), 32'(k == 16));
      chk("rst_len_out_valid", 32'(out_valid), 32'(k == 18));
      if (k == 18) begin
        chk("rst_len_out_ch", 32'(out_ch), 0);
        chk("rst_len_out_data", 32'(out_data), 301);
      end
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
